debounce_edge: RTL



---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_edge_sync_chain.sv | 23 ++
 rtl/debounce_edge.sv | 102 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared state encodings and helpers for the debounce_edge conditioning stage.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_CHK_HI    = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_CHK_LO    = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous input into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronise, debounce and edge-detect a raw input; outputs are all registered.
module debounce_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    import debounce_pkg::*;

    localparam int CNT_W = clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             din_s;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             level_nx, rise_nx, fall_nx, busy_nx;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (din),
        .q    (din_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
            busy  <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            ST_STABLE_LO: begin
                if (din_s) begin
                    state_nx = ST_CHK_HI;
                    cnt_nx   = CNT_W'(1);
                end
            end
            ST_CHK_HI: begin
                if (!din_s) begin
                    state_nx = ST_STABLE_LO;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_STABLE_HI;
                    level_nx = 1'b1;
                    rise_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_STABLE_HI: begin
                if (!din_s) begin
                    state_nx = ST_CHK_LO;
                    cnt_nx   = CNT_W'(1);
                end
            end
            ST_CHK_LO: begin
                if (din_s) begin
                    state_nx = ST_STABLE_HI;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_STABLE_LO;
                    level_nx = 1'b0;
                    fall_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
        endcase
        // busy is registered, so it reflects where the FSM is heading this edge
        busy_nx = (state_nx == ST_CHK_HI) || (state_nx == ST_CHK_LO);
    end

endmodule
